// File: rtl/controller_seq_pkg.sv
// Shared definitions for the instruction sequencer: state encodings, opcodes, ISR field layout.
// Ports: none (package only). Imported by controller_seq and its register-index decoder.
// Optional memory-wait behaviour (macro CTRL_MEM_WAIT_EN) lives in controller_seq, not here.
package ctrl_defs;

   // State codes are visible on the debug LEDs, so they are fixed values, not tool-chosen.
   typedef enum logic [3:0] {
      ST_FETCH     = 4'b0000,
      ST_DECODE    = 4'b0001,
      ST_EXEC_AX1  = 4'b0010,
      ST_EXEC_AX2  = 4'b0011,
      ST_EXEC_AX3  = 4'b0100,
      ST_EXEC_L    = 4'b0101,
      ST_EXEC_M    = 4'b0110,
      ST_INCREMENT = 4'b0111,
      ST_IDLE      = 4'b1000,
      ST_ERROR     = 4'b1111
   } state_t;

   localparam logic [1:0] OP_MOVE = 2'b00;
   localparam logic [1:0] OP_LOAD = 2'b01;
   localparam logic [1:0] OP_ADD  = 2'b10;
   localparam logic [1:0] OP_XOR  = 2'b11;

   // ISR layout: [7:6] opcode, [5:3] Rx (destination), [2:0] Ry (source).
   localparam int ISR_OP_LSB  = 6;
   localparam int ISR_RX_LSB  = 3;
   localparam int ISR_RY_LSB  = 0;
   // Low opcode bit distinguishes ADD (0) from XOR (1) within the ALU group.
   localparam int ISR_XOR_BIT = 6;

   function automatic logic [1:0] isr_op(input logic [7:0] isr);
      return isr[ISR_OP_LSB +: 2];
   endfunction

   function automatic logic [2:0] isr_rx(input logic [7:0] isr);
      return isr[ISR_RX_LSB +: 3];
   endfunction

   function automatic logic [2:0] isr_ry(input logic [7:0] isr);
      return isr[ISR_RY_LSB +: 3];
   endfunction

endpackage

// File: rtl/controller_seq_reg_onehot_dec.sv
// Register-index decoder: 3-bit register number plus enable -> NREG-wide one-hot vector.
// Ports: idx_i (register number), en_i (enable), onehot_o (all zero when en_i is low).
// Purely combinational; NREG must be 8 so every 3-bit index maps to exactly one bit.
module reg_onehot_dec
   import ctrl_defs::*;
#(
   parameter int NREG = 8
) (
   input  logic [2:0]      idx_i,
   input  logic            en_i,
   output logic [NREG-1:0] onehot_o
);

   always_comb begin
      onehot_o = '0;
      if (en_i) begin
         onehot_o[idx_i] = 1'b1;
      end
   end

endmodule

// File: rtl/controller_seq.sv
// Instruction sequencer: state register, Run/Done handshake, per-cycle datapath enables from ISR.
// Ports: Clock/Resetn/Run/ISR in; IR_in, PC_inc, R_in, R_out, DIN_out, A_in, G_in, G_out, AluXor, Done, Error, State out.
// Macro CTRL_MEM_WAIT_EN adds Mem_ready: FETCH and EXEC_L stretch until memory reports ready.
module controller_seq
   import ctrl_defs::*;
#(
   parameter int NREG     = 8,
   parameter int CONT_RUN = 1
) (
   input  logic            Clock,
   input  logic            Resetn,
   input  logic            Run,
`ifdef CTRL_MEM_WAIT_EN
   input  logic            Mem_ready,
`endif
   input  logic [7:0]      ISR,
   output logic            IR_in,
   output logic            PC_inc,
   output logic [NREG-1:0] R_in,
   output logic [NREG-1:0] R_out,
   output logic            DIN_out,
   output logic            A_in,
   output logic            G_in,
   output logic            G_out,
   output logic            AluXor,
   output logic            Done,
   output logic            Error,
   output logic [3:0]      State
);

   state_t     state_q, state_d;
   logic       run_q;
   logic       start;
   logic       mem_ok;
   logic       rin_en, rout_en;
   logic [2:0] rin_idx, rout_idx;

`ifdef CTRL_MEM_WAIT_EN
   assign mem_ok = Mem_ready;
`else
   assign mem_ok = 1'b1;
`endif

   // Single-shot mode starts only on a Run rising edge, so holding Run high
   // executes one instruction and then parks in IDLE.
   assign start = (CONT_RUN != 0) ? Run : (Run & ~run_q);

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state_q <= ST_IDLE;
         run_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         run_q   <= Run;
      end
   end

   always_comb begin
      state_d  = state_q;
      IR_in    = 1'b0;
      PC_inc   = 1'b0;
      DIN_out  = 1'b0;
      A_in     = 1'b0;
      G_in     = 1'b0;
      G_out    = 1'b0;
      AluXor   = 1'b0;
      Done     = 1'b0;
      Error    = 1'b0;
      rin_en   = 1'b0;
      rout_en  = 1'b0;
      rin_idx  = isr_rx(ISR);
      rout_idx = isr_ry(ISR);

      case (state_q)
         ST_IDLE: begin
            if (start) state_d = ST_FETCH;
         end
         ST_FETCH: begin
            IR_in = 1'b1;
            if (mem_ok) state_d = ST_DECODE;
         end
         ST_DECODE: begin
            case (isr_op(ISR))
               OP_MOVE: state_d = ST_EXEC_M;
               OP_LOAD: state_d = ST_EXEC_L;
               default: state_d = ST_EXEC_AX1;
            endcase
         end
         ST_EXEC_M: begin
            rout_en = 1'b1;
            rin_en  = 1'b1;
            state_d = ST_INCREMENT;
         end
         ST_EXEC_L: begin
            DIN_out = 1'b1;
            // Write only in the cycle the memory data is valid.
            rin_en  = mem_ok;
            if (mem_ok) state_d = ST_INCREMENT;
         end
         ST_EXEC_AX1: begin
            // First operand comes from the destination register.
            rout_en  = 1'b1;
            rout_idx = isr_rx(ISR);
            A_in     = 1'b1;
            state_d  = ST_EXEC_AX2;
         end
         ST_EXEC_AX2: begin
            rout_en = 1'b1;
            G_in    = 1'b1;
            AluXor  = ISR[ISR_XOR_BIT];
            state_d = ST_EXEC_AX3;
         end
         ST_EXEC_AX3: begin
            G_out   = 1'b1;
            rin_en  = 1'b1;
            state_d = ST_INCREMENT;
         end
         ST_INCREMENT: begin
            PC_inc  = 1'b1;
            Done    = 1'b1;
            state_d = ((CONT_RUN != 0) && Run) ? ST_FETCH : ST_IDLE;
         end
         ST_ERROR: begin
            // Sticky until Resetn; all enables stay low.
            Error = 1'b1;
         end
         default: begin
            state_d = ST_ERROR;
         end
      endcase
   end

   reg_onehot_dec #(.NREG(NREG)) u_rin_dec (
      .idx_i    (rin_idx),
      .en_i     (rin_en),
      .onehot_o (R_in)
   );

   reg_onehot_dec #(.NREG(NREG)) u_rout_dec (
      .idx_i    (rout_idx),
      .en_i     (rout_en),
      .onehot_o (R_out)
   );

   assign State = state_q;

endmodule

// File: doc/controller_seq.md
Name: controller_seq

Overview:
- Registered instruction sequencer for the 8-bit accumulator-less register datapath.
- Holds the state register and the Run/Done handshake.
- Decodes the instruction register into per-cycle datapath controls: register file, bus mux, ALU, instruction register and PC.
- Sits between the top-level Run switch/memory and the datapath. It is the only owner of datapath enables.

Parameters:
- NREG, 8: number of general registers; must equal 2**3 to match the 3-bit register fields.
- CONT_RUN, 1: 1 = keep executing while Run is high; 0 = execute exactly one instruction per Run rising edge.

Ports:
- Clock  in  1  system clock, rising edge.
- Resetn  in  1  asynchronous, active-low reset.
- Run  in  1  start request (level or edge per CONT_RUN).
- ISR  in  8  instruction register contents: [7:6] opcode (00 MOVE, 01 LOAD, 10 ADD, 11 XOR), [5:3] Rx (destination), [2:0] Ry (source).
- IR_in  out  1  load instruction register from memory data.
- PC_inc  out  1  increment program counter.
- R_in  out  NREG  one-hot register write enable.
- R_out  out  NREG  one-hot register bus drive.
- DIN_out  out  1  drive memory data onto bus.
- A_in  out  1  load ALU A operand register.
- G_in  out  1  load ALU result register G.
- G_out  out  1  drive G onto bus.
- AluXor  out  1  ALU op: 0 add, 1 xor.
- Done  out  1  one-cycle pulse on instruction completion.
- Error  out  1  sticky illegal-state flag.
- State  out  4  current state, for debug LEDs.

Behaviour:
- One clock domain. Resetn low asynchronously forces state IDLE (4'b1000). In IDLE every output is 0, including Done and Error, and State = 4'b1000. This holds for reset mid-instruction too: no partial writes after reset.
- Outputs are Moore-decoded from the state register plus ISR fields. Exactly one of R_out, DIN_out and G_out may be high in any cycle.
- State encodings: FETCH 0000, DECODE 0001, EXEC_AX1 0010, EXEC_AX2 0011, EXEC_AX3 0100, EXEC_L 0101, EXEC_M 0110, INCREMENT 0111, IDLE 1000, ERROR 1111.
- IDLE -> FETCH:
  - CONT_RUN=1: when Run=1.
  - CONT_RUN=0: on a Run rising edge, detected with registered run_q that resets to 0.
- FETCH: IR_in=1. Next state is DECODE.
- DECODE: no outputs. opcode 00 -> EXEC_M, 01 -> EXEC_L, 1x -> EXEC_AX1.
- EXEC_M: R_out[Ry]=1, R_in[Rx]=1. Next state is INCREMENT.
- EXEC_L: DIN_out=1, R_in[Rx]=1. Next state is INCREMENT.
- EXEC_AX1: R_out[Rx]=1, A_in=1.
- EXEC_AX2: R_out[Ry]=1, G_in=1, AluXor=ISR[6].
- EXEC_AX3: G_out=1, R_in[Rx]=1. Next state is INCREMENT.
- INCREMENT: PC_inc=1, Done=1. Next state is FETCH if CONT_RUN=1 and Run=1, otherwise IDLE.
- Latency, FETCH to Done inclusive: MOVE/LOAD 4 cycles, ADD/XOR 6 cycles.
- Run deasserted mid-instruction: the current instruction always completes; Run is only sampled in IDLE and INCREMENT.
- Rx == Ry is legal; outputs follow the same rules (e.g. ADD R3,R3 doubles R3).
- Any unencoded state -> ERROR. ERROR has all enables 0 and Error=1, and stays there until Resetn.
- ISR must be stable from DECODE until INCREMENT; the controller does not re-latch it.

Optional Feature:
- Macro CTRL_MEM_WAIT_EN.
- Defined:
  - Adds input Mem_ready (1 bit).
  - FETCH and EXEC_L hold their state and keep asserting their outputs until Mem_ready=1.
  - Transition occurs in the cycle Mem_ready=1 is sampled.
  - R_in is asserted in EXEC_L only while Mem_ready=1.
- Undefined: no Mem_ready port; FETCH and EXEC_L last exactly 1 cycle.

Decomposition:
- Shared include/package ctrl_defs: state encodings, opcode constants, ISR field bit positions.
- One sub-module reg_onehot_dec: 3-bit index plus enable -> NREG one-hot. Instanced twice, for R_in and R_out.

Test Plan:
- Reset, then Run=1 with ISR=8'b00_011_101 (MOVE R3,R5) -> IR_in in cycle 1; R_out=8'h20 and R_in=8'h08 in cycle 3; Done pulses in cycle 4.
- ISR=8'b10_001_010 (ADD R1,R2) -> R_out=02 with A_in; then R_out=04 with G_in and AluXor=0; then G_out with R_in=02; Done in cycle 6. For 8'b11_001_010, AluXor=1 in the AX2 cycle.
- CONT_RUN=0, Run held high for 20 cycles -> exactly one Done pulse, then IDLE. A second rising edge of Run -> one more Done.
- Resetn pulled low during EXEC_AX2 -> State=1000 and all outputs 0 immediately, without waiting for a clock edge; no R_in pulse afterwards.
- CTRL_MEM_WAIT_EN defined, LOAD R7 with Mem_ready low for 3 cycles in EXEC_L -> DIN_out held for 4 cycles; R_in=8'h80 only in the Mem_ready cycle; Done follows 1 cycle later.
- Force state register to 1010 -> ERROR, Error=1, no enables; remains there until Resetn.
